nibble_serial_adder: RTL and testbench

NIBBLE_SERIAL_ADDER -- requirements
Module: nibble_serial_adder

---
 rtl/nibble_serial_adder.sv | 113 +++++++++++
 tb/tb_nibble_serial_adder.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder.sv
// Nibble-serial adder: adds two 4*N_NIB-bit operands one 4-bit slice per clock,
// least-significant slice first, with a valid/ready handshake on each side.
module nibble_serial_adder #(
    parameter int N_NIB = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*N_NIB-1:0] a,
    input  logic [4*N_NIB-1:0] b,
    input  logic               cin,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [4*N_NIB-1:0] sum,
    output logic               cout,
    output logic               busy
);
    localparam int W     = 4 * N_NIB;
    localparam int IDX_W = (N_NIB > 1) ? $clog2(N_NIB) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_NIB - 1);

    typedef enum logic [1:0] {
        IDLE,
        ADD,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [W-1:0]     a_r;
    logic [W-1:0]     b_r;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [3:0]       nib_a;
    logic [3:0]       nib_b;
    logic [4:0]       slice;
    logic             accept;

    // 4-bit ripple-carry add; returns {carry_out, sum}.
    function automatic logic [4:0] rca4(input logic [3:0] x, input logic [3:0] y,
                                        input logic ci);
        logic       c;
        logic [3:0] s;
        c = ci;
        for (int i = 0; i < 4; i++) begin
            s[i] = x[i] ^ y[i] ^ c;
            c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
        end
        return {c, s};
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign busy      = (state != IDLE);
    assign accept    = in_valid & in_ready;

    always_comb begin
        nib_a = a_r[4*idx +: 4];
        nib_b = b_r[4*idx +: 4];
        slice = rca4(nib_a, nib_b, carry);
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (accept) state_nxt = ADD;
            ADD:  if (idx == IDX_LAST) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Operand copies are pure data: only ever read while a captured operation runs.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_r <= a;
            b_r <= b;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            if (state == IDLE && accept) begin
                carry <= cin;
                idx   <= '0;
                sum   <= '0;
            end else if (state == ADD) begin
                sum[4*idx +: 4] <= slice[3:0];
                carry           <= slice[4];
                if (idx == IDX_LAST) begin
                    cout <= slice[4];
                end else begin
                    idx <= idx + IDX_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Directed and randomised bench for nibble_serial_adder (N_NIB=4) with a
// queue-based scoreboard of expected {cout,sum} values.
module tb_nibble_serial_adder;
    localparam int N_NIB = 4;
    localparam int W     = 4 * N_NIB;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         busy;

    int vectors  = 0;
    int errors   = 0;
    int busy_cnt = 0;
    int lat      = 0;
    logic [W:0] exp_q[$];

    nibble_serial_adder #(.N_NIB(N_NIB)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one operand set for a single cycle; expects the block to be idle.
    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic c);
        chk("in_ready_idle", (W+1)'(in_ready), (W+1)'(1));
        a        = av;
        b        = bv;
        cin      = c;
        in_valid = 1'b1;
        exp_q.push_back((W+1)'(av) + (W+1)'(bv) + (W+1)'(c));
        step();
        in_valid = 1'b0;
        chk("sum_cleared_on_accept", (W+1)'(sum), '0);
        chk("busy_after_accept", (W+1)'(busy), (W+1)'(1));
    endtask

    // Wait (bounded) for out_valid and check its latency from the accept edge.
    task automatic wait_done();
        lat      = 0;
        busy_cnt = 0;
        while (!out_valid && lat < 20) begin
            if (!in_ready) busy_cnt++;
            step();
            lat++;
        end
        chk("out_valid_latency", (W+1)'(lat), (W+1)'(N_NIB));
    endtask

    task automatic receive(input int stall);
        logic [W:0] exp;
        if (exp_q.size() == 0) begin
            chk("scoreboard_empty", (W+1)'(1), '0);
            exp = '0;
        end else begin
            exp = exp_q.pop_front();
        end
        for (int s = 0; s < stall; s++) begin
            out_ready = 1'b0;
            chk("stall_out_valid", (W+1)'(out_valid), (W+1)'(1));
            chk("stall_result_hold", {cout, sum}, exp);
            if (!in_ready) busy_cnt++;
            step();
        end
        out_ready = 1'b1;
        chk("done_out_valid", (W+1)'(out_valid), (W+1)'(1));
        chk("result", {cout, sum}, exp);
        if (!in_ready) busy_cnt++;
        step();
        out_ready = 1'b0;
        chk("out_valid_one_cycle", (W+1)'(out_valid), '0);
        chk("in_ready_after_done", (W+1)'(in_ready), (W+1)'(1));
        chk("result_retained", {cout, sum}, exp);
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        a         = '0;
        b         = '0;
        cin       = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_sum_cout", {cout, sum}, '0);
        chk("rst_out_valid", (W+1)'(out_valid), '0);
        chk("rst_busy", (W+1)'(busy), '0);
        chk("rst_in_ready", (W+1)'(in_ready), (W+1)'(1));
        rst_n = 1'b1;
        step();

        // Full carry ripple through every slice.
        send(16'hFFFF, 16'h0001, 1'b0);
        wait_done();
        receive(0);

        // Carry-in and busy window length.
        send(16'h1234, 16'h4321, 1'b1);
        wait_done();
        receive(0);
        chk("in_ready_low_cycles", (W+1)'(busy_cnt), (W+1)'(N_NIB + 1));

        // Back-pressure: result must hold through three stalled cycles.
        send(16'h8000, 16'h8000, 1'b1);
        wait_done();
        receive(3);
        chk("stall_busy_cycles", (W+1)'(busy_cnt), (W+1)'(N_NIB + 4));

        // Operands changing while busy are ignored until the next IDLE cycle.
        send(16'h0F0F, 16'h00F1, 1'b0);
        a        = 16'hAAAA;
        b        = 16'h0000;
        cin      = 1'b0;
        in_valid = 1'b1;
        wait_done();
        receive(0);
        exp_q.push_back(17'h0AAAA);
        step();
        in_valid = 1'b0;
        chk("late_accept_busy", (W+1)'(busy), (W+1)'(1));
        wait_done();
        receive(0);

        // Reset in the middle of an operation aborts it.
        send(16'hFFFF, 16'hFFFF, 1'b0);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_sum_cout", {cout, sum}, '0);
        chk("midrst_out_valid", (W+1)'(out_valid), '0);
        chk("midrst_busy", (W+1)'(busy), '0);
        chk("midrst_in_ready", (W+1)'(in_ready), (W+1)'(1));
        void'(exp_q.pop_back());
        #3;
        rst_n = 1'b1;
        step();
        chk("postrst_idle_out_valid", (W+1)'(out_valid), '0);
        send(16'h0001, 16'h0002, 1'b0);
        wait_done();
        receive(0);

        // Random operands with random consumer stalls.
        for (int n = 0; n < 1000; n++) begin
            send(W'($urandom), W'($urandom), 1'($urandom));
            wait_done();
            receive(int'($urandom_range(0, 3)));
        end

        chk("scoreboard_drained", (W+1)'(exp_q.size()), '0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
